// File: rtl/shifter_pkg.sv
// Shared constants and the per-stage control record for the pipelined barrel shifter.
// Defining SHIFTER_CARRY_EN adds a carry-out field that travels with each beat.
package shifter_pkg;

  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic DIR_LEFT   = 1'b1;
  localparam logic FILL_LOGIC = 1'b0;
  localparam logic FILL_ARITH = 1'b1;

  // Sized for the widest supported WIDTH; each stage only looks at its own bit.
  localparam int SHW_MAX = 8;

  typedef struct packed {
    logic               valid;
    logic [SHW_MAX-1:0] shamt;
    logic               LR;
    logic               AL;
    logic               ROT;
    logic               sign;
`ifdef SHIFTER_CARRY_EN
    logic               cout;
`endif
  } stage_ctrl_t;

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Streaming valid/ready bundle for barrel_shifter_pipe.
// The cout signal exists only when SHIFTER_CARRY_EN is defined.
interface barrel_shifter_pipe_if #(parameter int WIDTH = 8);

  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic             LR;
  logic             AL;
  logic             ROT;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;

`ifdef SHIFTER_CARRY_EN
  logic             cout;

  modport master (output in_valid, din, shamt, LR, AL, ROT, out_ready,
                  input  in_ready, out_valid, dout, cout);
  modport slave  (input  in_valid, din, shamt, LR, AL, ROT, out_ready,
                  output in_ready, out_valid, dout, cout);
`else
  modport master (output in_valid, din, shamt, LR, AL, ROT, out_ready,
                  input  in_ready, out_valid, dout);
  modport slave  (input  in_valid, din, shamt, LR, AL, ROT, out_ready,
                  output in_ready, out_valid, dout);
`endif

endinterface

// File: rtl/shift_stage.sv
// One registered barrel-shifter stage: shifts by DIST when its shamt bit is set, else passes through.
// With SHIFTER_CARRY_EN the stage also updates the carried last-shifted-out bit.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  stage_ctrl_t      src_ctrl,
  input  logic [WIDTH-1:0] src_data,
  output stage_ctrl_t      ctrl,
  output logic [WIDTH-1:0] data
);

  localparam int BIT = $clog2(DIST);

  logic             apply;
  logic [WIDTH-1:0] shifted;
  stage_ctrl_t      next_ctrl;

  assign apply = src_ctrl.shamt[BIT];

  // Arithmetic fill uses the sign of the original din, carried in the control record.
  always_comb begin
    shifted = src_data;
    if (src_ctrl.ROT) begin
      if (src_ctrl.LR == DIR_LEFT)
        shifted = {src_data[WIDTH-1-DIST:0], src_data[WIDTH-1:WIDTH-DIST]};
      else
        shifted = {src_data[DIST-1:0], src_data[WIDTH-1:DIST]};
    end else if (src_ctrl.LR == DIR_LEFT) begin
      shifted = src_data << DIST;
    end else if (src_ctrl.AL == FILL_LOGIC) begin
      shifted = src_data >> DIST;
    end else begin
      shifted = {{DIST{src_ctrl.sign}}, src_data[WIDTH-1:DIST]};
    end
  end

  always_comb begin
    next_ctrl = src_ctrl;
`ifdef SHIFTER_CARRY_EN
    if (apply) begin
      if (src_ctrl.ROT)
        next_ctrl.cout = 1'b0;
      else if (src_ctrl.LR == DIR_RIGHT)
        next_ctrl.cout = src_data[DIST-1];
      else
        next_ctrl.cout = src_data[WIDTH-DIST];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl <= '0;
      data <= '0;
    end else if (advance) begin
      ctrl <= next_ctrl;
      data <= apply ? shifted : src_data;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (logical/arithmetic/rotate, left/right), one stage per shamt bit.
// Optional carry-out output is enabled by defining SHIFTER_CARRY_EN.
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  barrel_shifter_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             advance;
  stage_ctrl_t      in_ctrl;
  stage_ctrl_t      ctrl [SHW+1];
  logic [WIDTH-1:0] data [SHW+1];
  logic             unused_ctrl;

  // The whole pipe moves as one; bubbles are carried rather than squeezed out.
  assign advance      = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = advance;

  always_comb begin
    in_ctrl       = '0;
    in_ctrl.valid = bus.in_valid;
    in_ctrl.shamt = SHW_MAX'(bus.shamt);
    in_ctrl.LR    = bus.LR;
    in_ctrl.AL    = bus.AL;
    in_ctrl.ROT   = bus.ROT;
    in_ctrl.sign  = bus.din[WIDTH-1];
  end

  assign ctrl[0] = in_ctrl;
  assign data[0] = bus.din;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (advance),
      .src_ctrl (ctrl[k]),
      .src_data (data[k]),
      .ctrl     (ctrl[k+1]),
      .data     (data[k+1])
    );
  end

  assign bus.out_valid = ctrl[SHW].valid;
  assign bus.dout      = data[SHW];

`ifdef SHIFTER_CARRY_EN
  assign bus.cout = ctrl[SHW].cout;
`endif

  // Control fields of the last stage are not needed at the output.
  assign unused_ctrl = ^{ctrl[SHW].shamt, ctrl[SHW].LR, ctrl[SHW].AL,
                         ctrl[SHW].ROT, ctrl[SHW].sign};

endmodule
